data_memory_v2: RTL and testbench

DATA_MEMORY_V2 -- requirements
Module: data_memory_v2

---
 rtl/data_memory_v2.sv | 212 +++++++++++++++++++++
 tb/tb_data_memory_v2.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_v2.sv
// data_memory_v2: little-endian data/stack memory with a CPU load/store port and a NUL-terminated string streamer.
// Define DATA_MEMORY_FAULT_EN to enable the sticky access-fault flag; otherwise fault is tied low.
module data_memory_v2 #(
    parameter logic [31:0] DATA_BASE   = 32'h0040_0000,
    parameter int unsigned DATA_WORDS  = 1024,
    parameter logic [31:0] STACK_BASE  = 32'hFFFF_F000,
    parameter int unsigned STACK_WORDS = 1024,
    parameter int unsigned MAX_STR     = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a,
    input  logic [31:0] write_data,
    input  logic        mem_write,
    input  logic        mem_read,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    output logic [31:0] rd,
    input  logic        str_start,
    input  logic [31:0] a0,
    output logic [7:0]  char_data,
    output logic        char_valid,
    input  logic        char_ready,
    output logic        str_busy,
    output logic        str_done,
    output logic        fault
);
    localparam int DAW = (DATA_WORDS > 1) ? $clog2(DATA_WORDS) : 1;
    localparam int SAW = (STACK_WORDS > 1) ? $clog2(STACK_WORDS) : 1;
    localparam int CW  = $clog2(MAX_STR + 1);
    localparam logic [32:0] DATA_BYTES  = 33'(DATA_WORDS) << 2;
    localparam logic [32:0] STACK_BYTES = 33'(STACK_WORDS) << 2;

    logic [31:0] data_mem  [DATA_WORDS];
    logic [31:0] stack_mem [STACK_WORDS];

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EMIT, S_DONE} state_t;

    state_t         state_q, state_d;
    logic [31:0]    ptr_q, ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [7:0]     char_q, char_d;
    logic           valid_q, valid_d;
    logic           done_q, done_d;

    // CPU port decode
    logic [31:0]    c_doff, c_soff, c_word, c_shifted, wd_shifted;
    logic           c_dhit, c_shit, misalign, acc_ok;
    logic [DAW-1:0] c_didx;
    logic [SAW-1:0] c_sidx;
    logic [3:0]     be;

    assign c_doff = a - DATA_BASE;
    assign c_soff = a - STACK_BASE;
    assign c_dhit = {1'b0, c_doff} < DATA_BYTES;
    assign c_shit = {1'b0, c_soff} < STACK_BYTES;
    assign c_didx = c_doff[DAW+1:2];
    assign c_sidx = c_soff[SAW+1:2];

    always_comb begin
        case (mem_size)
            2'b00:   misalign = 1'b0;
            2'b01:   misalign = a[0];
            default: misalign = |a[1:0];
        endcase
    end

    assign acc_ok = (c_dhit | c_shit) & ~misalign;

    always_comb begin
        c_word = '0;
        if (c_dhit)      c_word = data_mem[c_didx];
        else if (c_shit) c_word = stack_mem[c_sidx];
    end

    assign c_shifted  = c_word >> {a[1:0], 3'b000};
    assign wd_shifted = write_data << {a[1:0], 3'b000};

    always_comb begin
        rd = '0;
        if (mem_read && acc_ok) begin
            case (mem_size)
                2'b00:   rd = mem_unsigned ? {24'h0, c_shifted[7:0]}
                                           : {{24{c_shifted[7]}}, c_shifted[7:0]};
                2'b01:   rd = mem_unsigned ? {16'h0, c_shifted[15:0]}
                                           : {{16{c_shifted[15]}}, c_shifted[15:0]};
                default: rd = c_shifted;
            endcase
        end
    end

    always_comb begin
        case (mem_size)
            2'b00:   be = 4'b0001 << a[1:0];
            2'b01:   be = 4'b0011 << a[1:0];
            default: be = 4'b1111;
        endcase
    end

    // Memory contents survive reset, so the array has no reset branch
    always_ff @(posedge clk) begin
        if (mem_write && acc_ok) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    if (c_dhit) data_mem[c_didx][8*i +: 8]  <= wd_shifted[8*i +: 8];
                    else        stack_mem[c_sidx][8*i +: 8] <= wd_shifted[8*i +: 8];
                end
            end
        end
    end

    // Streamer read path on live memory
    logic [31:0]    p_doff, p_soff, p_word;
    logic           p_dhit, p_shit, p_hit;
    logic [7:0]     p_byte;

    assign p_doff = ptr_q - DATA_BASE;
    assign p_soff = ptr_q - STACK_BASE;
    assign p_dhit = {1'b0, p_doff} < DATA_BYTES;
    assign p_shit = {1'b0, p_soff} < STACK_BYTES;
    assign p_hit  = p_dhit | p_shit;

    always_comb begin
        p_word = '0;
        if (p_dhit)      p_word = data_mem[p_doff[DAW+1:2]];
        else if (p_shit) p_word = stack_mem[p_soff[SAW+1:2]];
    end

    always_comb begin
        case (ptr_q[1:0])
            2'd0:    p_byte = p_word[7:0];
            2'd1:    p_byte = p_word[15:8];
            2'd2:    p_byte = p_word[23:16];
            default: p_byte = p_word[31:24];
        endcase
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        char_d  = char_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (str_start) begin
                    state_d = S_FETCH;
                    ptr_d   = a0;
                    cnt_d   = '0;
                end
            end
            S_FETCH: begin
                if (!p_hit || p_byte == 8'h00 || cnt_q == CW'(MAX_STR)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    char_d  = p_byte;
                    valid_d = 1'b1;
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                if (char_ready) begin
                    valid_d = 1'b0;
                    ptr_d   = ptr_q + 32'd1;
                    cnt_d   = cnt_q + CW'(1);
                    state_d = S_FETCH;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            char_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            char_q  <= char_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign char_data  = char_q;
    assign char_valid = valid_q;
    assign str_done   = done_q;
    assign str_busy   = (state_q != S_IDLE);

`ifdef DATA_MEMORY_FAULT_EN
    logic fault_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                      fault_q <= 1'b0;
        else if ((mem_read || mem_write) && !acc_ok)    fault_q <= 1'b1;
    end

    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_data_memory_v2.sv
// tb_data_memory_v2: randomized CPU traffic and string streams checked against a byte-addressed reference model.
module tb_data_memory_v2;
    localparam longint unsigned DB  = 64'h0040_0000;
    localparam longint unsigned SB  = 64'hFFFF_F000;
    localparam longint unsigned SEG = 64'd4096;
    localparam int MAXS = 256;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] a = '0, write_data = '0, a0 = '0;
    logic        mem_write = 1'b0, mem_read = 1'b0, mem_unsigned = 1'b0;
    logic [1:0]  mem_size = 2'b10;
    logic [31:0] rd;
    logic        str_start = 1'b0, char_ready = 1'b0;
    logic [7:0]  char_data;
    logic        char_valid, str_busy, str_done, fault;

    int n_total = 0;
    int n_bad = 0;

    logic [7:0] mem_m [bit [31:0]];
    logic       model_fault = 1'b0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    data_memory_v2 dut (
        .clk(clk), .reset(reset), .a(a), .write_data(write_data),
        .mem_write(mem_write), .mem_read(mem_read), .mem_size(mem_size),
        .mem_unsigned(mem_unsigned), .rd(rd), .str_start(str_start), .a0(a0),
        .char_data(char_data), .char_valid(char_valid), .char_ready(char_ready),
        .str_busy(str_busy), .str_done(str_done), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic bit in_rng(input bit [31:0] ad);
        longint unsigned x;
        x = 64'(ad);
        return (x >= DB && x < DB + SEG) || (x >= SB && x < SB + SEG);
    endfunction

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit bad_acc(input bit [31:0] ad, input logic [1:0] sz);
        bit mis;
        mis = (sz == 2'b01) ? ad[0] : (sz[1] ? (ad[1:0] != 2'b00) : 1'b0);
        return mis || !in_rng(ad);
    endfunction

    function automatic logic [7:0] mget(input bit [31:0] ad);
        return mem_m.exists(ad) ? mem_m[ad] : 8'h00;
    endfunction

    function automatic logic [31:0] model_rd(input bit [31:0] ad, input logic [1:0] sz,
                                             input logic re, input logic uns);
        logic [31:0] v;
        int n;
        v = '0;
        n = nbytes(sz);
        if (!re || bad_acc(ad, sz)) return 32'h0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = mget(ad + 32'(i));
        if (n == 1 && !uns) v = {{24{v[7]}}, v[7:0]};
        if (n == 2 && !uns) v = {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    task automatic cpu_op(input string tag, input logic [31:0] ad, input logic [1:0] sz,
                          input logic we, input logic re, input logic uns,
                          input logic [31:0] wd, output logic [31:0] got);
        @(negedge clk);
        a = ad; write_data = wd; mem_size = sz;
        mem_write = we; mem_read = re; mem_unsigned = uns;
        #1;
        got = rd;
        chk(tag, rd, model_rd(ad, sz, re, uns));
        chk("fault", {31'd0, fault}, {31'd0, model_fault});
        @(posedge clk);
        if (we && !bad_acc(ad, sz))
            for (int i = 0; i < nbytes(sz); i++) mem_m[ad + 32'(i)] = wd[8*i +: 8];
`ifdef DATA_MEMORY_FAULT_EN
        if ((we || re) && bad_acc(ad, sz)) model_fault = 1'b1;
`endif
        #1;
        mem_write = 1'b0;
        mem_read  = 1'b0;
    endtask

    task automatic build_exp(input logic [31:0] st);
        bit [31:0] p;
        exp_q.delete();
        p = st;
        while (exp_q.size() < MAXS && in_rng(p) && mget(p) != 8'h00) begin
            exp_q.push_back(mget(p));
            p = p + 32'd1;
        end
    endtask

    // mode 0: ready always high, 1: toggling, 2: random
    task automatic run_stream(input string tag, input logic [31:0] st, input int mode,
                              input bit inject);
        bit         seen_done, hold, inj_pending;
        logic [7:0] hold_d;
        int         nchk;
        build_exp(st);
        got_q.delete();
        seen_done = 0; hold = 0; inj_pending = 0; hold_d = '0;
        @(negedge clk);
        a0 = st; str_start = 1'b1;
        @(posedge clk);
        #1 str_start = 1'b0;
        for (int cyc = 0; cyc < 3000 && !seen_done; cyc++) begin
            @(negedge clk);
            if (inj_pending) begin str_start = 1'b0; inj_pending = 0; end
            case (mode)
                0:       char_ready = 1'b1;
                1:       char_ready = cyc[0];
                default: char_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (hold) begin
                chk({tag, "_hold_valid"}, {31'd0, char_valid}, 32'd1);
                chk({tag, "_hold_data"}, {24'd0, char_data}, {24'd0, hold_d});
            end
            if (char_valid && char_ready) got_q.push_back(char_data);
            hold = char_valid && !char_ready;
            hold_d = char_data;
            if (str_done) seen_done = 1;
            if (inject && cyc == 6 && str_busy) begin
                a0 = 32'h0040_0000; str_start = 1'b1; inj_pending = 1;
            end
            @(posedge clk);
        end
        #1 char_ready = 1'b0; str_start = 1'b0;
        chk({tag, "_done_seen"}, {31'd0, seen_done}, 32'd1);
        @(negedge clk); #1;
        chk({tag, "_done_width"}, {31'd0, str_done}, 32'd0);
        chk({tag, "_busy_after"}, {31'd0, str_busy}, 32'd0);
        chk({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
        nchk = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < nchk; i++) chk({tag, "_char"}, {24'd0, got_q[i]}, {24'd0, exp_q[i]});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic [31:0] ad;
        bit found, stray;
        int hs;
        logic [31:0] oor [4];

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, char_valid}, 32'd0);
        chk("rst_data",  {24'd0, char_data}, 32'd0);
        chk("rst_busy",  {31'd0, str_busy}, 32'd0);
        chk("rst_done",  {31'd0, str_done}, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        @(negedge clk) reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            cpu_op("pre_d", 32'(DB) + 32'(4*i), 2'b10, 1, 0, 0, $urandom, r);
            cpu_op("pre_s", 32'(SB) + 32'(4*i), 2'b10, 1, 0, 0, $urandom, r);
        end
        for (int i = 0; i < 4; i++) begin
            cpu_op("pre_de", 32'(DB + SEG) - 32'd16 + 32'(4*i), 2'b10, 1, 0, 0, $urandom, r);
            cpu_op("pre_se", 32'hFFFF_FFF0 + 32'(4*i), 2'b10, 1, 0, 0, $urandom, r);
        end

        cpu_op("st042", 32'h0040_0000, 2'b10, 1, 0, 0, 32'hDEAD_BEEF, r);
        cpu_op("ld042s", 32'h0040_0003, 2'b00, 0, 1, 0, 32'h0, r);
        chk("ld042s_const", r, 32'hFFFF_FFDE);
        cpu_op("ld042u", 32'h0040_0003, 2'b00, 0, 1, 1, 32'h0, r);
        chk("ld042u_const", r, 32'h0000_00DE);

        cpu_op("st043w", 32'hFFFF_F000, 2'b10, 1, 0, 0, 32'h0, r);
        cpu_op("st043h", 32'hFFFF_F002, 2'b01, 1, 0, 0, 32'h0000_1234, r);
        cpu_op("ld043", 32'hFFFF_F000, 2'b10, 0, 1, 0, 32'h0, r);
        chk("ld043_const", r, 32'h1234_0000);

        cpu_op("st044", 32'h0040_0002, 2'b10, 1, 1, 0, 32'h5555_AAAA, r);
        chk("st044_rd0", r, 32'h0);
        @(negedge clk); #1;
`ifdef DATA_MEMORY_FAULT_EN
        chk("flt044", {31'd0, fault}, 32'd1);
`else
        chk("flt044", {31'd0, fault}, 32'd0);
`endif
        cpu_op("ld044", 32'h0040_0000, 2'b10, 0, 1, 0, 32'h0, r);
        chk("ld044_const", r, 32'hDEAD_BEEF);

        oor[0] = 32'h003F_FFFC; oor[1] = 32'(DB + SEG); oor[2] = 32'(SB) - 32'd8; oor[3] = 32'h0000_0010;
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 5))
                0, 1:    ad = 32'(DB) + $urandom_range(0, 63);
                2:       ad = 32'(SB) + $urandom_range(0, 63);
                3:       ad = 32'(DB + SEG) - 32'd16 + $urandom_range(0, 15);
                4:       ad = 32'hFFFF_FFF0 + $urandom_range(0, 15);
                default: ad = oor[$urandom_range(0, 3)] + $urandom_range(0, 7);
            endcase
            cpu_op("rnd", ad, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), $urandom, r);
        end

        cpu_op("hi_w0", 32'h0040_0200, 2'b10, 1, 0, 0, 32'h0, r);
        cpu_op("hi_w1", 32'h0040_0204, 2'b10, 1, 0, 0, 32'h0, r);
        cpu_op("hi_H", 32'h0040_0201, 2'b00, 1, 0, 0, 32'h48, r);
        cpu_op("hi_i", 32'h0040_0202, 2'b00, 1, 0, 0, 32'h69, r);
        cpu_op("hi_x", 32'h0040_0203, 2'b00, 1, 0, 0, 32'h21, r);
        run_stream("hi", 32'h0040_0201, 1, 0);
        chk("hi_len_const", 32'(got_q.size()), 32'd3);

        for (int i = 0; i < 76; i++)
            cpu_op("run_w", 32'h0040_0400 + 32'(4*i), 2'b10, 1, 0, 0,
                   {8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)),
                    8'($urandom_range(1, 255)), 8'($urandom_range(1, 255))}, r);
        run_stream("max", 32'h0040_0400, 2, 1);
        chk("max_len_const", 32'(got_q.size()), 32'd256);

        for (int i = 0; i < 8; i++)
            cpu_op("end_b", 32'h0040_0FF8 + 32'(i), 2'b00, 1, 0, 0, 32'($urandom_range(1, 255)), r);
        run_stream("segend", 32'h0040_0FF8, 0, 0);

        @(negedge clk);
        a0 = 32'h0040_0201; str_start = 1'b1;
        @(posedge clk);
        #1 str_start = 1'b0; char_ready = 1'b1;
        hs = 0; found = 0;
        for (int cyc = 0; cyc < 50 && !found; cyc++) begin
            @(negedge clk); #1;
            if (char_valid && hs == 1) found = 1;
            else begin
                if (char_valid && char_ready) hs++;
                @(posedge clk);
            end
        end
        chk("rst047_found", {31'd0, found}, 32'd1);
        reset = 1'b1;
        #1;
        chk("rst047_valid", {31'd0, char_valid}, 32'd0);
        chk("rst047_busy",  {31'd0, str_busy}, 32'd0);
        chk("rst047_done",  {31'd0, str_done}, 32'd0);
        chk("rst047_data",  {24'd0, char_data}, 32'd0);
        model_fault = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0; char_ready = 1'b0;
        stray = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            if (str_done || str_busy) stray = 1;
        end
        chk("rst047_quiet", {31'd0, stray}, 32'd0);
        cpu_op("ld_keep", 32'h0040_0201, 2'b00, 0, 1, 1, 32'h0, r);
        chk("ld_keep_const", r, 32'h0000_0048);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
